// File: rtl/alu_muldiv_seq.sv
// XLEN-wide ALU with RV32I base ops (1-cycle) and iterative M-extension mul/div (XLEN+1 cycles).
// Valid/ready on both sides; one op in flight at a time.
module alu_muldiv_seq #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    input  logic            MulDiv,
    input  logic [3:0]      ALUControl,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] ALUOut,
    output logic            Zero,
    output logic            Negative,
    output logic            busy
);

    localparam int unsigned SHAMT_W = $clog2(XLEN);
    localparam int unsigned PROD_W  = 2 * XLEN;
    localparam logic [SHAMT_W-1:0] CNT_LAST = SHAMT_W'(XLEN - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    logic               accept_c;
    logic               last_c;
    logic [SHAMT_W-1:0] cnt;

    // Latched M-op context
    logic [2:0]         op_q;
    logic               res_neg_q;
    logic               rem_neg_q;
    logic               div_zero_q;
    logic [PROD_W-1:0]  prod_q;
    logic [XLEN-1:0]    mcand_q;
    logic [XLEN-1:0]    quo_q;
    logic [XLEN-1:0]    rem_q;
    logic [XLEN-1:0]    div_q;

    logic               a_neg_c;
    logic               b_neg_c;
    logic [XLEN-1:0]    base_res_c;

    logic [XLEN-1:0]    addend_c;
    logic [XLEN:0]      sum_c;
    logic [PROD_W-1:0]  prod_nxt_c;
    logic [XLEN:0]      r_shift_c;
    logic               ge_c;
    logic [XLEN-1:0]    rem_nxt_c;
    logic [XLEN-1:0]    quo_nxt_c;
    logic [PROD_W-1:0]  prod_full_c;
    logic [XLEN-1:0]    quo_fix_c;
    logic [XLEN-1:0]    rem_fix_c;
    logic [XLEN-1:0]    md_res_c;

    function automatic logic [XLEN-1:0] base_op(
        input logic [3:0]      ctl,
        input logic [XLEN-1:0] a,
        input logic [XLEN-1:0] b
    );
        logic [SHAMT_W-1:0] sh;
        sh = b[SHAMT_W-1:0];
        case (ctl)
            4'd0:    base_op = a + b;
            4'd1:    base_op = a - b;
            4'd2:    base_op = a & b;
            4'd3:    base_op = a | b;
            4'd4:    base_op = a ^ b;
            4'd5:    base_op = a << sh;
            4'd6:    base_op = a >> sh;
            4'd7:    base_op = XLEN'($signed(a) >>> sh);
            4'd8:    base_op = XLEN'($signed(a) < $signed(b));
            4'd9:    base_op = XLEN'(a < b);
            default: base_op = '0;
        endcase
    endfunction

    function automatic logic [XLEN-1:0] mag(
        input logic [XLEN-1:0] x,
        input logic            neg
    );
        mag = neg ? -x : x;
    endfunction

    // State register and registered handshake/status outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= state_nxt;
            in_ready  <= (state_nxt == IDLE);
            out_valid <= (state_nxt == DONE);
            busy      <= (state_nxt != IDLE);
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        accept_c  = 1'b0;
        last_c    = 1'b0;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    accept_c  = 1'b1;
                    state_nxt = MulDiv ? CALC : DONE;
                end
            end
            CALC: begin
                if (cnt == CNT_LAST) begin
                    last_c    = 1'b1;
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Operand signedness: div ops use bit 0 as "unsigned", mul ops MULHSU/MULHU drop rs2/both signs
    always_comb begin
        a_neg_c = 1'b0;
        b_neg_c = 1'b0;
        if (ALUControl[2]) begin
            a_neg_c = !ALUControl[0] && rs1[XLEN-1];
            b_neg_c = !ALUControl[0] && rs2[XLEN-1];
        end else begin
            a_neg_c = (ALUControl[1:0] != 2'd3) && rs1[XLEN-1];
            b_neg_c = !ALUControl[1] && rs2[XLEN-1];
        end
    end

    always_comb begin
        base_res_c = base_op(ALUControl, rs1, rs2);
    end

    // One shift-add multiply step and one restoring-divide step, on magnitudes
    always_comb begin
        addend_c   = prod_q[0] ? mcand_q : '0;
        sum_c      = {1'b0, prod_q[PROD_W-1:XLEN]} + {1'b0, addend_c};
        prod_nxt_c = {sum_c, prod_q[XLEN-1:1]};
        r_shift_c  = {rem_q, quo_q[XLEN-1]};
        ge_c       = (r_shift_c >= {1'b0, div_q});
        rem_nxt_c  = ge_c ? (r_shift_c[XLEN-1:0] - div_q) : r_shift_c[XLEN-1:0];
        quo_nxt_c  = {quo_q[XLEN-2:0], ge_c};
    end

    // Sign fix-up and result select; a zero divisor forces an all-ones quotient
    always_comb begin
        prod_full_c = res_neg_q ? -prod_nxt_c : prod_nxt_c;
        quo_fix_c   = div_zero_q ? '1 : (res_neg_q ? -quo_nxt_c : quo_nxt_c);
        rem_fix_c   = rem_neg_q ? -rem_nxt_c : rem_nxt_c;
        case (op_q)
            3'd0:       md_res_c = prod_full_c[XLEN-1:0];
            3'd1, 3'd2,
            3'd3:       md_res_c = prod_full_c[PROD_W-1:XLEN];
            3'd4, 3'd5: md_res_c = quo_fix_c;
            default:    md_res_c = rem_fix_c;
        endcase
    end

    // Datapath registers and registered result/flags
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt        <= '0;
            op_q       <= '0;
            res_neg_q  <= 1'b0;
            rem_neg_q  <= 1'b0;
            div_zero_q <= 1'b0;
            prod_q     <= '0;
            mcand_q    <= '0;
            quo_q      <= '0;
            rem_q      <= '0;
            div_q      <= '0;
            ALUOut     <= '0;
            Zero       <= 1'b1;
            Negative   <= 1'b0;
        end else if (accept_c) begin
            cnt <= '0;
            if (MulDiv) begin
                op_q       <= ALUControl[2:0];
                res_neg_q  <= a_neg_c ^ b_neg_c;
                rem_neg_q  <= a_neg_c;
                div_zero_q <= (rs2 == '0);
                prod_q     <= {{XLEN{1'b0}}, mag(rs2, b_neg_c)};
                mcand_q    <= mag(rs1, a_neg_c);
                quo_q      <= mag(rs1, a_neg_c);
                rem_q      <= '0;
                div_q      <= mag(rs2, b_neg_c);
            end else begin
                ALUOut   <= base_res_c;
                Zero     <= (base_res_c == '0);
                Negative <= base_res_c[XLEN-1];
            end
        end else if (state == CALC) begin
            cnt    <= cnt + SHAMT_W'(1);
            prod_q <= prod_nxt_c;
            quo_q  <= quo_nxt_c;
            rem_q  <= rem_nxt_c;
            if (last_c) begin
                ALUOut   <= md_res_c;
                Zero     <= (md_res_c == '0);
                Negative <= md_res_c[XLEN-1];
            end
        end
    end

endmodule

// File: tb/tb_alu_muldiv_seq.sv
// Directed testbench for alu_muldiv_seq (XLEN=32): base ops, mul/div, backpressure, reset.
module tb_alu_muldiv_seq;

    localparam int unsigned XLEN = 32;

    logic            clk = 1'b0;
    logic            rst;
    logic            in_valid;
    logic            in_ready;
    logic [XLEN-1:0] rs1;
    logic [XLEN-1:0] rs2;
    logic            MulDiv;
    logic [3:0]      ALUControl;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] ALUOut;
    logic            Zero;
    logic            Negative;
    logic            busy;

    int checks = 0;
    int errors = 0;

    alu_muldiv_seq #(.XLEN(XLEN)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .rs1        (rs1),
        .rs2        (rs2),
        .MulDiv     (MulDiv),
        .ALUControl (ALUControl),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .ALUOut     (ALUOut),
        .Zero       (Zero),
        .Negative   (Negative),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Issue one op, wait (bounded) for the result, check latency/value/flags, then handshake it out
    task automatic run_op(input string tag, input logic md, input logic [3:0] ctl,
                          input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                          input logic [XLEN-1:0] exp, input int exp_lat);
        int lat;
        int rdy_seen;
        @(negedge clk);
        check({tag, "/in_ready"}, 64'(in_ready), 64'd1);
        in_valid   = 1'b1;
        MulDiv     = md;
        ALUControl = ctl;
        rs1        = a;
        rs2        = b;
        out_ready  = 1'b0;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        lat      = 1;
        rdy_seen = 0;
        while (!out_valid && lat < 100) begin
            if (in_ready || !busy) rdy_seen++;
            @(negedge clk);
            lat++;
        end
        check({tag, "/latency"}, 64'(lat), 64'(exp_lat));
        check({tag, "/stall"}, 64'(rdy_seen), 64'd0);
        check({tag, "/result"}, 64'(ALUOut), 64'(exp));
        check({tag, "/zero"}, 64'(Zero), 64'(exp == '0));
        check({tag, "/neg"}, 64'(Negative), 64'(exp[XLEN-1]));
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check({tag, "/drain"}, 64'(out_valid), 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int saw_valid;
        int saw_busy;
        rst        = 1'b1;
        in_valid   = 1'b0;
        out_ready  = 1'b0;
        MulDiv     = 1'b0;
        ALUControl = 4'd0;
        rs1        = '0;
        rs2        = '0;
        repeat (2) @(negedge clk);
        check("rst/out_valid", 64'(out_valid), 64'd0);
        check("rst/in_ready", 64'(in_ready), 64'd1);
        check("rst/busy", 64'(busy), 64'd0);
        check("rst/ALUOut", 64'(ALUOut), 64'd0);
        check("rst/Zero", 64'(Zero), 64'd1);
        rst = 1'b0;

        // Base ops
        run_op("add",   1'b0, 4'd0,  32'd5,          32'd10,         32'd15,         1);
        run_op("sub",   1'b0, 4'd1,  32'd5,          32'd10,         32'hFFFF_FFFB,  1);
        run_op("and",   1'b0, 4'd2,  32'h0000_F0F0,  32'h0000_FF00,  32'h0000_F000,  1);
        run_op("or",    1'b0, 4'd3,  32'h0000_F0F0,  32'h0000_FF00,  32'h0000_FFF0,  1);
        run_op("xor",   1'b0, 4'd4,  32'h0000_F0F0,  32'h0000_FF00,  32'h0000_0FF0,  1);
        run_op("sll",   1'b0, 4'd5,  32'd1,          32'd33,         32'd2,          1);
        run_op("sra",   1'b0, 4'd7,  32'h8000_00F5,  32'd3,          32'hF000_001E,  1);
        run_op("srl",   1'b0, 4'd6,  32'h8000_00F5,  32'd3,          32'h1000_001E,  1);
        run_op("slt",   1'b0, 4'd8,  32'd30,         32'hFFFF_FFF6,  32'd0,          1);
        run_op("sltu",  1'b0, 4'd9,  32'd30,         32'hFFFF_FFF6,  32'd1,          1);
        run_op("op12",  1'b0, 4'd12, 32'd7,          32'd9,          32'd0,          1);

        // Multiply
        run_op("mul",    1'b1, 4'd0, 32'hFFFF_FFF9, 32'd3,  32'hFFFF_FFEB, 33);
        run_op("mulh",   1'b1, 4'd1, 32'hFFFF_FFF9, 32'd3,  32'hFFFF_FFFF, 33);
        run_op("mulhu",  1'b1, 4'd3, 32'hFFFF_FFFF, 32'd2,  32'd1,         33);
        run_op("mulhsu", 1'b1, 4'd2, 32'hFFFF_FFFF, 32'd2,  32'hFFFF_FFFF, 33);
        run_op("mul_b3", 1'b1, 4'd8, 32'd1234,      32'd1000, 32'd1234000, 33);

        // Divide
        run_op("div",      1'b1, 4'd4, 32'hFFFF_FFEC, 32'd3,         32'hFFFF_FFFA, 33);
        run_op("rem",      1'b1, 4'd6, 32'hFFFF_FFEC, 32'd3,         32'hFFFF_FFFE, 33);
        run_op("divu",     1'b1, 4'd5, 32'd100,       32'd7,         32'd14,        33);
        run_op("remu",     1'b1, 4'd7, 32'd100,       32'd7,         32'd2,         33);
        run_op("divu0",    1'b1, 4'd5, 32'd30,        32'd0,         32'hFFFF_FFFF, 33);
        run_op("remu0",    1'b1, 4'd7, 32'd30,        32'd0,         32'd30,        33);
        run_op("div0neg",  1'b1, 4'd4, 32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFFF, 33);
        run_op("rem0neg",  1'b1, 4'd6, 32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9, 33);
        run_op("divovf",   1'b1, 4'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 33);
        run_op("removf",   1'b1, 4'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         33);

        // Backpressure: result held, new op ignored until the handshake completes
        @(negedge clk);
        in_valid = 1'b1; MulDiv = 1'b0; ALUControl = 4'd0; rs1 = 32'd1; rs2 = 32'd2;
        out_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("bp/valid", 64'(out_valid), 64'd1);
        ALUControl = 4'd1; rs1 = 32'd9; rs2 = 32'd4;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp/hold_out", 64'(ALUOut), 64'd3);
            check("bp/hold_valid", 64'(out_valid), 64'd1);
            check("bp/hold_ready", 64'(in_ready), 64'd0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("bp/idle_valid", 64'(out_valid), 64'd0);
        check("bp/idle_ready", 64'(in_ready), 64'd1);
        check("bp/idle_out", 64'(ALUOut), 64'd3);
        @(negedge clk);
        in_valid = 1'b0;
        check("bp/new_valid", 64'(out_valid), 64'd1);
        check("bp/new_out", 64'(ALUOut), 64'd5);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;

        // Reset mid-divide with a competing op on the reset edge
        @(negedge clk);
        in_valid = 1'b1; MulDiv = 1'b1; ALUControl = 4'd5; rs1 = 32'd1000; rs2 = 32'd7;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (9) @(negedge clk);
        check("rstcalc/busy_before", 64'(busy), 64'd1);
        rst = 1'b1;
        in_valid = 1'b1; MulDiv = 1'b0; ALUControl = 4'd0; rs1 = 32'd1; rs2 = 32'd1;
        @(negedge clk);
        rst = 1'b0;
        in_valid = 1'b0;
        check("rstcalc/out_valid", 64'(out_valid), 64'd0);
        check("rstcalc/in_ready", 64'(in_ready), 64'd1);
        check("rstcalc/busy", 64'(busy), 64'd0);
        check("rstcalc/ALUOut", 64'(ALUOut), 64'd0);
        check("rstcalc/Zero", 64'(Zero), 64'd1);
        check("rstcalc/Negative", 64'(Negative), 64'd0);
        saw_valid = 0;
        saw_busy  = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (out_valid) saw_valid++;
            if (busy) saw_busy++;
        end
        check("rstcalc/no_result", 64'(saw_valid), 64'd0);
        check("rstcalc/no_accept", 64'(saw_busy), 64'd0);

        run_op("after_rst", 1'b0, 4'd0, 32'd2, 32'd2, 32'd4, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_muldiv_seq.md
Name: alu_muldiv_seq

Overview:
- Parametrised successor to the single-cycle RV32I ALU.
- Executes base integer ops (1-cycle latency) and RV M-extension multiply/divide ops (iterative, fixed latency) on an XLEN-wide datapath.
- Uses valid/ready handshakes on input and output.
- Sits in the EX stage; the pipeline stalls on in_ready=0 or on out_valid&&!out_ready.

Parameters:
- XLEN, 32, datapath width; legal values 8..64, power of 2.
- SHAMT_W, $clog2(XLEN), shift-amount width; derived localparam, not overridable.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous reset, active-high
- in_valid  in  1  operands/op presented
- in_ready  out  1  block can accept an op
- rs1  in  XLEN  operand A
- rs2  in  XLEN  operand B
- MulDiv  in  1  0 = base op, 1 = M-extension op
- ALUControl  in  4  op select
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- ALUOut  out  XLEN  result
- Zero  out  1  ALUOut == 0
- Negative  out  1  ALUOut[XLEN-1]
- busy  out  1  state != IDLE

Behaviour:
- Base encoding (MulDiv=0): 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 SRA, 8 SLT, 9 SLTU; codes 10-15 produce 0.
- M encoding (MulDiv=1, low 3 bits; bit 3 ignored): 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- Shifts use rs2[SHAMT_W-1:0] only.
- ADD/SUB wrap modulo 2^XLEN; no overflow flag.
- SLT/SLTU return 1 or 0, zero-extended.
- FSM states:
  - IDLE: in_ready=1. An accept (in_valid&&in_ready) latches operands and op. Base op goes to DONE; M op goes to CALC with cnt=0.
  - CALC: one shift-add (mul) or restoring-subtract (div) step per cycle on magnitudes. cnt increments; at cnt==XLEN-1, sign fix-up is applied, the result is registered, and the FSM goes to DONE.
  - DONE: out_valid=1; ALUOut, Zero and Negative are stable. If out_ready, go to IDLE on the next edge; otherwise hold.
- Latency, measured from the accept edge to the first cycle with out_valid=1:
  - Base op: 1 cycle.
  - M op: XLEN+1 cycles, fixed and data-independent, including divide-by-zero.
- in_ready=0 in CALC and DONE. in_valid in those states is ignored; nothing is queued.
- Earliest back-to-back accept is the cycle after the out_valid&&out_ready handshake, because in_ready is registered from state.
- Signed ops operate on magnitudes; result sign follows RISC-V rules:
  - Quotient is negative iff operand signs differ.
  - Remainder takes the sign of the dividend.
  - MULHSU treats rs1 as signed and rs2 as unsigned.
- Divide by zero:
  - DIV/DIVU return all ones.
  - REM/REMU return rs1.
- Signed overflow (rs1 = -2^(XLEN-1), rs2 = -1):
  - DIV returns rs1.
  - REM returns 0.
- Zero and Negative are computed from the registered ALUOut, so they are valid exactly when out_valid=1.
- Outputs other than those listed below hold their last value while out_valid=0.
- Reset, at any time including mid-CALC or DONE, takes effect on the next edge:
  - state=IDLE, cnt=0
  - out_valid=0, in_ready=1, busy=0
  - ALUOut=0, Zero=1, Negative=0
- Any in-flight op is discarded.
- rst has priority over in_valid on the same edge.

Test Plan:
1. ADD 5+10, then SUB 5-10, XLEN=32 -> ALUOut=15, Zero=0, valid 1 cycle after accept. Next ALUOut=0xFFFFFFFB, Negative=1.
2. SRA rs1=0x800000F5, rs2=3 -> 0xF000001E. SRL same operands -> 0x1000001E. SLT 30 vs -10 -> 0. SLTU 30 vs -10 -> 1.
3. MUL and MULH with -7 and 3 -> MUL=0xFFFFFFEB, MULH=0xFFFFFFFF, MULHU(0xFFFFFFFF,2)=1. out_valid exactly 33 cycles after accept; in_ready=0 throughout.
4. Divide cases:
   - DIV -20/3 -> 0xFFFFFFFA; REM -20/3 -> 0xFFFFFFFE.
   - DIVU 30/0 -> 0xFFFFFFFF; REMU 30/0 -> 30.
   - DIV 0x80000000/-1 -> 0x80000000; REM -> 0, Zero=1.
   - All with 33-cycle latency.
5. Backpressure: hold out_ready=0 for 5 cycles after out_valid, with in_valid=1 and a new op presented -> ALUOut held and stable, in_ready=0, new op not accepted. Raise out_ready -> IDLE next cycle, then the new op is accepted.
6. Reset: assert rst at CALC cycle 10 of a DIVU, with in_valid=1 on the same edge -> next cycle out_valid=0, in_ready=1, busy=0, ALUOut=0, Zero=1. No result emerges later, and the op presented with rst is not accepted.
